// File: rtl/vec_dot_acc.sv
// vec_dot_acc: sequential accumulator that sits directly after the vector multiply/dot unit.
// A job sums a programmed number of VEC_SIZE-wide partial dot products, supplied one per chunk
// over a valid/ready handshake. The scalar result is presented on a registered valid/ready
// output, so the accumulator can handle vectors longer than VEC_SIZE.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_start            job start; taken in IDLE, or in DONE together with the output handshake
//   i_num_chunks       chunk count for the job, clamped to MAX_CHUNKS when a start is taken
//   i_abort            synchronous abort to IDLE; overrides every handshake and start
//   i_dot/_valid       partial dot product input; o_dot_ready is high only in ACC
//   o_result/_valid    accumulated dot product; i_result_ready completes the output handshake
//   o_busy             high in ACC or DONE
//   o_chunk_cnt        chunks accepted so far in the current job
//
// Accumulation uses the shared fixed-point saturating add (fixpoint_add).

`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 32
`endif

module vec_dot_acc #(
  parameter int unsigned MAX_CHUNKS = 256,
  parameter int unsigned CNT_W      = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [CNT_W-1:0]           i_num_chunks,
  input  logic                       i_abort,
  input  logic [`FIXPOINT_WIDTH-1:0] i_dot,
  input  logic                       i_dot_valid,
  output logic                       o_dot_ready,
  output logic [`FIXPOINT_WIDTH-1:0] o_result,
  output logic                       o_result_valid,
  input  logic                       i_result_ready,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_chunk_cnt
);

  localparam int unsigned FpW = `FIXPOINT_WIDTH;
  localparam logic [CNT_W-1:0] MaxN = CNT_W'(MAX_CHUNKS);

  // Two's-complement add that saturates to the most positive/negative value on overflow.
  function automatic logic [FpW-1:0] fixpoint_add(input logic [FpW-1:0] a,
                                                  input logic [FpW-1:0] b);
    logic [FpW-1:0] s;
    s = a + b;
    if ((a[FpW-1] == b[FpW-1]) && (s[FpW-1] != a[FpW-1])) begin
      s = a[FpW-1] ? {1'b1, {(FpW-1){1'b0}}} : {1'b0, {(FpW-1){1'b1}}};
    end
    return s;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FpW-1:0]   acc_q, acc_d;
  logic [FpW-1:0]   result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic [CNT_W-1:0] n_clamped;
  logic [FpW-1:0]   acc_sum;
  logic             in_hs;
  logic             out_hs;

  assign n_clamped = (i_num_chunks > MaxN) ? MaxN : i_num_chunks;
  assign acc_sum   = fixpoint_add(acc_q, i_dot);
  assign in_hs     = i_dot_valid && (state_q == StAcc);
  assign out_hs    = result_valid_q && i_result_ready;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    if (i_abort) begin
      state_d        = StIdle;
      result_valid_d = 1'b0;
      cnt_d          = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            n_d   = n_clamped;
            acc_d = '0;
            cnt_d = '0;
            if (n_clamped == '0) begin
              // Empty job: result is zero and is offered immediately.
              state_d        = StDone;
              result_d       = '0;
              result_valid_d = 1'b1;
            end else begin
              state_d = StAcc;
            end
          end
        end

        StAcc: begin
          if (in_hs) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == n_q - CNT_W'(1)) begin
              result_d       = acc_sum;
              result_valid_d = 1'b1;
              state_d        = StDone;
            end
          end
        end

        StDone: begin
          if (out_hs) begin
            result_valid_d = 1'b0;
            // A start coinciding with the output handshake chains straight into the next job.
            if (i_start) begin
              n_d   = n_clamped;
              acc_d = '0;
              cnt_d = '0;
              if (n_clamped == '0) begin
                state_d        = StDone;
                result_d       = '0;
                result_valid_d = 1'b1;
              end else begin
                state_d = StAcc;
              end
            end else begin
              state_d = StIdle;
            end
          end
        end

        default: begin
          state_d        = StIdle;
          result_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      n_q            <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Handshake outputs decode from state only; nothing combinational reaches o_result.
  assign o_dot_ready    = (state_q == StAcc);
  assign o_busy         = (state_q != StIdle);
  assign o_result       = result_q;
  assign o_result_valid = result_valid_q;
  assign o_chunk_cnt    = cnt_q;

endmodule

// File: tb/tb_vec_dot_acc.sv
// Bench for vec_dot_acc: scenario tasks with a saturating-integer reference model (Q16.16).

`ifndef FIXPOINT_WIDTH
`define FIXPOINT_WIDTH 32
`endif

module tb_vec_dot_acc;

  localparam int unsigned MaxChunks = 256;
  localparam int unsigned CntW      = $clog2(MaxChunks + 1);
  localparam logic [31:0] One       = 32'h0001_0000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CntW-1:0] num_chunks;
  logic            abort;
  logic [31:0]     dot;
  logic            dot_valid;
  logic            dot_ready;
  logic [31:0]     result;
  logic            result_valid;
  logic            result_ready;
  logic            busy;
  logic [CntW-1:0] chunk_cnt;

  int vectors;
  int miscompares;

  logic [31:0] chunk_mem [0:299];

  vec_dot_acc #(
    .MAX_CHUNKS(MaxChunks)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_num_chunks  (num_chunks),
    .i_abort       (abort),
    .i_dot         (dot),
    .i_dot_valid   (dot_valid),
    .o_dot_ready   (dot_ready),
    .o_result      (result),
    .o_result_valid(result_valid),
    .i_result_ready(result_ready),
    .o_busy        (busy),
    .o_chunk_cnt   (chunk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum, clamped to the 32-bit signed range after every addition.
  function automatic logic [31:0] model_sum(input int base, input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = s + longint'($signed(chunk_mem[base + i]));
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
    end
    return 32'(s);
  endfunction

  task automatic start_job(input int n);
    start      = 1'b1;
    num_chunks = CntW'(n);
    tick();
    start      = 1'b0;
  endtask

  // Presents chunks [base, base+count) one per cycle after a random idle gap.
  task automatic feed(input int base, input int count, input int max_gap, output int accepted);
    int gap;
    accepted = 0;
    for (int i = 0; i < count; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        dot_valid = 1'b0;
        dot       = $urandom;
        tick();
      end
      dot       = chunk_mem[base + i];
      dot_valid = 1'b1;
      if (dot_ready) accepted++;
      tick();
    end
    dot_valid = 1'b0;
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({dot_ready, result_valid, busy} !== 3'b000 || result !== 32'h0 || chunk_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset: ready/valid/busy=%b result=%h cnt=%0d, required 000/0/0",
               {dot_ready, result_valid, busy}, result, chunk_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int acc;
    for (int i = 0; i < 4; i++) chunk_mem[i] = One * (i + 1);
    start_job(4);
    feed(0, 3, 0, acc);
    vectors++;
    if (result_valid !== 1'b0 || chunk_cnt !== CntW'(3) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_pre: valid=%b cnt=%0d busy=%b, required 0/3/1",
               result_valid, chunk_cnt, busy);
    end
    feed(3, 1, 0, acc);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'h000A_0000 || chunk_cnt !== CntW'(4)) begin
      miscompares++;
      $display("FAIL basic_result: valid=%b result=%h cnt=%0d, required 1/000a0000/4",
               result_valid, result, chunk_cnt);
    end
    vectors++;
    if (busy !== 1'b1 || dot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: busy=%b ready=%b, required 1/0", busy, dot_ready);
    end
    take_result();
    vectors++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h000A_0000) begin
      miscompares++;
      $display("FAIL basic_idle: busy=%b valid=%b result=%h, required 0/0/000a0000",
               busy, result_valid, result);
    end
  endtask

  task automatic test_gaps();
    int acc;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) chunk_mem[i] = $urandom_range(32'h0010_0000, 0);
    exp = model_sum(0, 3);
    start_job(3);
    feed(0, 3, 3, acc);
    vectors++;
    if (acc != 3) begin
      miscompares++;
      $display("FAIL gaps_accept: accepted=%0d, required 3", acc);
    end
    for (int c = 0; c < 5; c++) begin
      dot_valid = 1'b1;
      dot       = $urandom;
      vectors++;
      if (result_valid !== 1'b1 || result !== exp || dot_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL gaps_hold%0d: valid=%b result=%h ready=%b, required 1/%h/0",
                 c, result_valid, result, dot_ready, exp);
      end
      tick();
    end
    dot_valid = 1'b0;
    take_result();
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gaps_release: valid=%b busy=%b, required 0/0", result_valid, busy);
    end
  endtask

  task automatic test_zero();
    dot_valid = 1'b1;
    dot       = One;
    start_job(0);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'h0 || dot_ready !== 1'b0 || busy !== 1'b1 ||
        chunk_cnt !== '0) begin
      miscompares++;
      $display("FAIL zero: valid=%b result=%h ready=%b busy=%b cnt=%0d, required 1/0/0/1/0",
               result_valid, result, dot_ready, busy, chunk_cnt);
    end
    dot_valid = 1'b0;
    take_result();
  endtask

  task automatic test_back_to_back();
    int acc;
    chunk_mem[0] = 32'h0001_8000;
    chunk_mem[1] = 32'h0000_8000;
    start_job(2);
    feed(0, 2, 0, acc);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'h0002_0000) begin
      miscompares++;
      $display("FAIL b2b_first: valid=%b result=%h, required 1/00020000", result_valid, result);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    num_chunks   = CntW'(1);
    tick();
    result_ready = 1'b0;
    start        = 1'b0;
    vectors++;
    if (busy !== 1'b1 || dot_ready !== 1'b1 || result_valid !== 1'b0 || chunk_cnt !== '0) begin
      miscompares++;
      $display("FAIL b2b_chain: busy=%b ready=%b valid=%b cnt=%0d, required 1/1/0/0",
               busy, dot_ready, result_valid, chunk_cnt);
    end
    chunk_mem[0] = 32'hFFFF_0000;
    feed(0, 1, 0, acc);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'hFFFF_0000) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b result=%h, required 1/ffff0000", result_valid, result);
    end
    take_result();
  endtask

  task automatic test_abort();
    int acc;
    bit seen;
    for (int i = 0; i < 5; i++) chunk_mem[i] = One;
    start_job(5);
    feed(0, 2, 0, acc);
    abort     = 1'b1;
    dot_valid = 1'b1;
    dot       = One;
    tick();
    abort     = 1'b0;
    dot_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || dot_ready !== 1'b0 || result_valid !== 1'b0 || chunk_cnt !== '0) begin
      miscompares++;
      $display("FAIL abort: busy=%b ready=%b valid=%b cnt=%0d, required 0/0/0/0",
               busy, dot_ready, result_valid, chunk_cnt);
    end
    seen = 1'b0;
    repeat (4) begin
      if (result_valid) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_noresult: result_valid seen=1, required 0");
    end
    chunk_mem[0] = 32'h0000_4000;
    start_job(1);
    feed(0, 1, 0, acc);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL abort_next: valid=%b result=%h, required 1/00004000", result_valid, result);
    end
    take_result();
  endtask

  task automatic test_async_reset();
    int acc;
    for (int i = 0; i < 5; i++) chunk_mem[i] = One;
    start_job(5);
    feed(0, 2, 0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || dot_ready !== 1'b0 || result_valid !== 1'b0 || chunk_cnt !== '0 ||
        result !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b ready=%b valid=%b cnt=%0d result=%h, required 0/0/0/0/0",
               busy, dot_ready, result_valid, chunk_cnt, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chunk_mem[0] = 32'h0000_4000;
    start_job(1);
    feed(0, 1, 0, acc);
    vectors++;
    if (result_valid !== 1'b1 || result !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL async_next: valid=%b result=%h, required 1/00004000", result_valid, result);
    end
    take_result();
  endtask

  task automatic test_clamp();
    int acc;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) chunk_mem[i] = One;
    exp = model_sum(0, MaxChunks);
    start_job(300);
    feed(0, 300, 0, acc);
    vectors++;
    if (acc != int'(MaxChunks) || chunk_cnt !== CntW'(MaxChunks)) begin
      miscompares++;
      $display("FAIL clamp_count: accepted=%0d cnt=%0d, required %0d", acc, chunk_cnt, MaxChunks);
    end
    vectors++;
    if (result_valid !== 1'b1 || result !== exp || dot_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_result: valid=%b result=%h ready=%b, required 1/%h/0",
               result_valid, result, dot_ready, exp);
    end
    take_result();
  endtask

  task automatic test_random();
    int acc;
    int n;
    logic [31:0] exp;
    for (int j = 0; j < 20; j++) begin
      n = int'($urandom_range(8, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) == 0) chunk_mem[i] = $urandom;
        else chunk_mem[i] = $urandom_range(32'h0010_0000, 0) - 32'h0008_0000;
      end
      exp = model_sum(0, n);
      start_job(n);
      feed(0, n, 2, acc);
      vectors++;
      if (result_valid !== 1'b1 || result !== exp || chunk_cnt !== CntW'(n)) begin
        miscompares++;
        $display("FAIL random%0d: valid=%b result=%h cnt=%0d, required 1/%h/%0d",
                 j, result_valid, result, chunk_cnt, exp, n);
      end
      repeat ($urandom_range(2, 0)) tick();
      take_result();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random%0d_idle: busy=%b, required 0", j, busy);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    num_chunks   = '0;
    abort        = 1'b0;
    dot          = '0;
    dot_valid    = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_clamp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
